// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state encoding for the UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state, even parity).
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);
  localparam logic        IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  localparam int unsigned STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter for the UART transmitter.
// Ports:
//   clk   - system clock (rising edge)
//   rst   - synchronous active-high reset
//   clear - holds the counter at 0 (used while the transmitter is idle)
//   tick  - registered 1-cycle pulse during the cycle the count is BIT_CYCLES-1
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(BIT_CYCLES - 2);

  logic [CNT_W-1:0] cnt;

  // tick is registered one count early so it lines up with cnt == LAST
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == PRE_LAST);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit asynchronous serial transmitter, LSB first, idle-high line.
// Frame is 8N1 by default; with UART_TX_PARITY_EN defined an even parity bit
// is inserted between data bit 7 and the stop bit (8E1).
// Ports:
//   clk      - system clock (rising edge)
//   rst      - synchronous active-high reset
//   tx_data  - byte to send, latched on accept
//   tx_valid - upstream has a byte on tx_data
//   tx_ready - block can accept a byte (accept = tx_valid && tx_ready)
//   tx_busy  - frame in progress (always ~tx_ready)
//   tx       - registered serial line output
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned BIT_CYCLES = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  state_t                 state;
  logic [DATA_BITS-1:0]   shift;
  logic [BIT_IDX_W-1:0]   bit_cnt;
  logic                   tick;
  logic                   baud_clear;
`ifdef UART_TX_PARITY_EN
  logic                   parity_bit;
`endif

  // Counter is parked at 0 in IDLE so the start bit gets a full period
  assign baud_clear = (state == IDLE);

  uart_baud_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  // Frame sequencer; tx/tx_ready/tx_busy change on the same edge as the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      tx       <= IDLE_LEVEL;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift    <= tx_data;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
          end
        end
        START: begin
          if (tick) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= IDLE_LEVEL;
              state <= STOP;
`endif
            end else begin
              // next bit is shift[1] because the shift lands on this same edge
              tx      <= shift[1];
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BIT_IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx    <= IDLE_LEVEL;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          tx       <= IDLE_LEVEL;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Instance u_a runs at 16 cycles/bit,
// instance u_b at the default 868 cycles/bit. A behavioural receiver per line
// decodes frames into queues; expected bytes are queued when driven.
// Honours UART_TX_PARITY_EN to expect the 11-bit frame.
module tb_uart_tx;

  localparam int unsigned BC_A = 16;
  localparam int unsigned BC_B = 100000000 / 115200;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       frame_ok;
    int         fall_cyc;
  } rx_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_a = 8'h00;
  logic [7:0] data_b = 8'h00;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;
  logic       ready_a, busy_a, tx_a;
  logic       ready_b, busy_b, tx_b;

  int cyc = 0;
  int acc_a = 0;
  int abort_a = 0;
  int abort_b = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  rx_t        rxq_a[$];
  rx_t        rxq_b[$];
  logic [7:0] expq_a[$];
  logic [7:0] expq_b[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (!rst && valid_a && ready_a) acc_a <= acc_a + 1;

  uart_tx #(.CLK_FREQ(16), .BAUD(1)) u_a (
    .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx_busy(busy_a), .tx(tx_a)
  );

  uart_tx u_b (
    .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx_busy(busy_b), .tx(tx_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural receiver: every sample of each bit must hold one level
  task automatic monitor(input bit sel);
    int   bc;
    logic prev;
    logic v;
    logic val;
    bit   abort;
    rx_t  r;
    bc   = sel ? int'(BC_B) : int'(BC_A);
    prev = 1'b0;
    val  = 1'b1;
    forever begin
      @(negedge clk);
      v = sel ? tx_b : tx_a;
      if (!rst && prev === 1'b1 && v === 1'b0) begin
        r.fall_cyc = cyc;
        r.data     = 8'h00;
        r.par      = 1'b0;
        r.frame_ok = 1'b1;
        abort      = 1'b0;
        for (int b = 0; b < int'(FRAME_BITS) && !abort; b++) begin
          for (int s = 0; s < bc && !abort; s++) begin
            if (b != 0 || s != 0) begin
              @(negedge clk);
              v = sel ? tx_b : tx_a;
            end
            if (rst) abort = 1'b1;
            else if (s == 0) val = v;
            else if (v !== val) r.frame_ok = 1'b0;
          end
          if (!abort) begin
            if (b == 0) begin
              if (val !== 1'b0) r.frame_ok = 1'b0;
            end else if (b <= 8) begin
              r.data[b-1] = val;
            end else if (b == int'(FRAME_BITS) - 1) begin
              if (val !== 1'b1) r.frame_ok = 1'b0;
            end else begin
              r.par = val;
            end
          end
        end
        if (abort) begin
          if (sel) abort_b++;
          else abort_a++;
        end else if (sel) rxq_b.push_back(r);
        else rxq_a.push_back(r);
      end
      prev = v;
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  // Waits until ready is seen high at a negedge; k = negedges waited
  task automatic wait_ready(input bit sel, input int budget, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(sel ? ready_b : ready_a) && k < budget);
  endtask

  // Pops received frames against expected bytes
  task automatic score(input bit sel, input string tag, output string hex);
    rx_t        r;
    logic [7:0] e;
    hex = "";
    if (sel) chk({tag, " count"}, 32'(rxq_b.size()), 32'(expq_b.size()));
    else     chk({tag, " count"}, 32'(rxq_a.size()), 32'(expq_a.size()));
    while (sel ? (rxq_b.size() > 0 && expq_b.size() > 0)
               : (rxq_a.size() > 0 && expq_a.size() > 0)) begin
      if (sel) begin
        r = rxq_b.pop_front();
        e = expq_b.pop_front();
      end else begin
        r = rxq_a.pop_front();
        e = expq_a.pop_front();
      end
      hex = $sformatf("%s%02x", hex, r.data);
      chk({tag, " data"}, 32'(r.data), 32'(e));
      chk({tag, " frame"}, 32'(r.frame_ok), 32'd1);
`ifdef UART_TX_PARITY_EN
      chk({tag, " parity"}, 32'(r.par), 32'(^e));
`endif
    end
    if (sel) begin rxq_b.delete(); expq_b.delete(); end
    else     begin rxq_a.delete(); expq_a.delete(); end
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    k;
    int    acc0;
    int    ab0;
    int    lows;
    int    fall1;
    rx_t   r;
    string hex;
    logic [7:0] bytes_b [4];

    // Reset held 3 cycles
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst tx_a", 32'(tx_a), 32'd1);
      chk("rst ready_a", 32'(ready_a), 32'd1);
      chk("rst busy_a", 32'(busy_a), 32'd0);
      chk("rst tx_b", 32'(tx_b), 32'd1);
      chk("rst ready_b", 32'(ready_b), 32'd1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x55
    chk("pre tx idle", 32'(tx_a), 32'd1);
    data_a = 8'h55; valid_a = 1'b1; expq_a.push_back(8'h55);
    @(negedge clk);
    valid_a = 1'b0;
    chk("55 start low", 32'(tx_a), 32'd0);
    chk("55 ready low", 32'(ready_a), 32'd0);
    chk("55 busy high", 32'(busy_a), 32'd1);
    k = cyc;
    wait_ready(1'b0, 400, k);
    chk("55 frame len", 32'(k), 32'(FRAME_BITS * BC_A));
    chk("55 busy after", 32'(busy_a), 32'd0);
    repeat (2) @(negedge clk);
    chk("55 fall count", 32'(rxq_a.size()), 32'd1);
    score(1'b0, "55", hex);

    // Back-to-back 0xA5, 0x3C with tx_valid held
    acc0 = acc_a;
    data_a = 8'hA5; valid_a = 1'b1; expq_a.push_back(8'hA5);
    @(negedge clk);
    chk("b2b first accept", 32'(ready_a), 32'd0);
    data_a = 8'h3C; expq_a.push_back(8'h3C);
    wait_ready(1'b0, 400, k);
    chk("b2b first len", 32'(k), 32'(FRAME_BITS * BC_A));
    @(negedge clk);
    chk("b2b second start", 32'(tx_a), 32'd0);
    chk("b2b second ready", 32'(ready_a), 32'd0);
    valid_a = 1'b0;
    repeat (50) @(negedge clk);
    data_a = 8'h00; valid_a = 1'b1;   // must be ignored mid-frame
    @(negedge clk);
    valid_a = 1'b0;
    wait_ready(1'b0, 400, k);
    repeat (2) @(negedge clk);
    chk("b2b accepts", 32'(acc_a - acc0), 32'd2);
    if (rxq_a.size() >= 2) begin
      fall1 = rxq_a[0].fall_cyc;
      r = rxq_a[1];
      chk("b2b fall gap", 32'(r.fall_cyc - fall1), 32'(FRAME_BITS * BC_A + 1));
    end else begin
      chk("b2b frames seen", 32'(rxq_a.size()), 32'd2);
    end
    score(1'b0, "b2b", hex);

    // Reset during DATA bit 3 of 0xFF
    ab0 = abort_a;
    data_a = 8'hFF; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    repeat (4 * BC_A + 5 - 1) @(negedge clk);
    chk("ff in bit3 busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst tx", 32'(tx_a), 32'd1);
    chk("midrst ready", 32'(ready_a), 32'd1);
    chk("midrst busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_a !== 1'b1) lows++;
    end
    chk("midrst no lows", 32'(lows), 32'd0);
    chk("midrst abort", 32'(abort_a - ab0), 32'd1);
    chk("midrst no frame", 32'(rxq_a.size()), 32'd0);
    data_a = 8'h5A; valid_a = 1'b1; expq_a.push_back(8'h5A);
    @(negedge clk);
    valid_a = 1'b0;
    wait_ready(1'b0, 400, k);
    chk("post rst len", 32'(k), 32'(FRAME_BITS * BC_A));
    repeat (2) @(negedge clk);
    score(1'b0, "post rst", hex);

    // Parity cases (frame length depends on build)
    data_a = 8'h07; valid_a = 1'b1; expq_a.push_back(8'h07);
    @(negedge clk);
    valid_a = 1'b0;
    wait_ready(1'b0, 400, k);
    chk("07 frame len", 32'(k), 32'(FRAME_BITS * BC_A));
    repeat (2) @(negedge clk);
`ifdef UART_TX_PARITY_EN
    if (rxq_a.size() > 0) chk("07 parity bit", 32'(rxq_a[0].par), 32'd1);
`endif
    score(1'b0, "07", hex);
    data_a = 8'h03; valid_a = 1'b1; expq_a.push_back(8'h03);
    @(negedge clk);
    valid_a = 1'b0;
    wait_ready(1'b0, 400, k);
    chk("03 frame len", 32'(k), 32'(FRAME_BITS * BC_A));
    repeat (2) @(negedge clk);
`ifdef UART_TX_PARITY_EN
    if (rxq_a.size() > 0) chk("03 parity bit", 32'(rxq_a[0].par), 32'd0);
`endif
    score(1'b0, "03", hex);

    // Default rate: "ABCD" through the receiver model
    bytes_b[0] = 8'h41; bytes_b[1] = 8'h42; bytes_b[2] = 8'h43; bytes_b[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      data_b = bytes_b[i]; valid_b = 1'b1; expq_b.push_back(bytes_b[i]);
      @(negedge clk);
      valid_b = 1'b0;
      chk("868 start low", 32'(tx_b), 32'd0);
      wait_ready(1'b1, 12000, k);
      chk("868 frame len", 32'(k), 32'(FRAME_BITS * BC_B));
    end
    repeat (2) @(negedge clk);
    score(1'b1, "868", hex);
    $display("rx model: %s", hex);
    chk("868 string", 32'(hex == "41424344"), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
